// File: rtl/cache_pkg.sv
// Shared types and defaults for the cache controller slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_pkg;

  // Default geometry: 32-word blocks, 8 lines.
  localparam int OFFSET_W_DEF = 5;
  localparam int INDEX_W_DEF  = 3;

  // Controller states.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOOKUP     = 3'd1,
    ST_WRITE_HIT  = 3'd2,
    ST_READ_HIT   = 3'd3,
    ST_WRITEBACK  = 3'd4,
    ST_REFILL     = 3'd5,
    ST_FLUSH_SCAN = 3'd6
  } state_t;

endpackage

// File: rtl/cache_burst_cnt.sv
// Word counter for SDRAM bursts; advances on each accepted word, flags the last word.
// Latency: count updates one cycle after the accepted word.
// Backpressure: holds its value while no word is accepted.
module cache_burst_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  output logic [W-1:0] cnt,
  output logic         last
);

  // Counter wraps all-ones -> 0 only on the final accepted word of a burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (adv) begin
      cnt <= cnt + W'(1);
    end
  end

  assign last = &cnt;

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Direct-mapped cache controller: hit handling, dirty write-back, refill and flush-all.
// Latency: hit = 2 cycles after request; miss adds 2^OFFSET_W acked words per burst.
// Backpressure: rdy low while busy; SDRAM words stall until mem_ack.
module cache_ctrl_fsm
  import cache_pkg::*;
#(
  parameter int OFFSET_W = OFFSET_W_DEF,
  parameter int INDEX_W  = INDEX_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cs,
  input  logic                wr_rd_cpu,
  input  logic [INDEX_W-1:0]  index,
  input  logic                tag_match,
  input  logic                flush,
  input  logic                mem_ack,
  output logic                rdy,
  output logic [INDEX_W-1:0]  line_idx,
  output logic [OFFSET_W-1:0] addr_offset,
  output logic                memstrb,
  output logic                wr_rd_sdram,
  output logic                mux_sel,
  output logic                demux_sel,
  output logic                wen_sram,
  output logic                tag_wen,
  output logic                flush_done
);

  localparam int LINES = 1 << INDEX_W;

  state_t               state_q, state_d;
  logic                 wr_q, wr_d;
  logic [INDEX_W-1:0]   line_q, line_d;
  logic [INDEX_W-1:0]   scan_q, scan_d;
  logic                 flush_mode_q, flush_mode_d;
  logic [LINES-1:0]     valid_q, valid_d;
  logic [LINES-1:0]     dirty_q, dirty_d;
  logic                 tag_wen_q, tag_wen_d;

  logic                 burst_adv;
  logic                 burst_last;
  logic                 last_ack;
  logic                 hit;
  logic                 scan_dirty;

  // SDRAM strobe is purely state-decoded so acks can never count outside a burst.
  assign memstrb    = (state_q == ST_WRITEBACK) || (state_q == ST_REFILL);
  assign burst_adv  = memstrb & mem_ack;
  assign last_ack   = burst_adv & burst_last;
  assign hit        = tag_match & valid_q[line_q];
  assign scan_dirty = valid_q[scan_q] & dirty_q[scan_q];
  assign line_idx   = line_q;
  assign tag_wen    = tag_wen_q;

  cache_burst_cnt #(
    .W (OFFSET_W)
  ) u_burst_cnt (
    .clk  (clk),
    .rst  (rst),
    .adv  (burst_adv),
    .cnt  (addr_offset),
    .last (burst_last)
  );

  // State and bookkeeping registers; reset aborts any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_q         <= 1'b0;
      line_q       <= '0;
      scan_q       <= '0;
      flush_mode_q <= 1'b0;
      valid_q      <= '0;
      dirty_q      <= '0;
      tag_wen_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      line_q       <= line_d;
      scan_q       <= scan_d;
      flush_mode_q <= flush_mode_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      tag_wen_q    <= tag_wen_d;
    end
  end

  // Next-state, line bookkeeping and Moore outputs (wen_sram follows mem_ack in REFILL).
  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    line_d       = line_q;
    scan_d       = scan_q;
    flush_mode_d = flush_mode_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_wen_d    = 1'b0;

    rdy          = 1'b0;
    wr_rd_sdram  = 1'b0;
    mux_sel      = 1'b0;
    demux_sel    = 1'b0;
    wen_sram     = 1'b0;
    flush_done   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rdy = 1'b1;
        if (flush) begin
          // Flush takes priority; a simultaneous cs is dropped.
          flush_mode_d = 1'b1;
          scan_d       = '0;
          line_d       = '0;
          state_d      = ST_FLUSH_SCAN;
        end else if (cs) begin
          flush_mode_d = 1'b0;
          wr_d         = wr_rd_cpu;
          line_d       = index;
          state_d      = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        if (hit) begin
          state_d = wr_q ? ST_WRITE_HIT : ST_READ_HIT;
        end else if (valid_q[line_q] && dirty_q[line_q]) begin
          state_d = ST_WRITEBACK;
        end else begin
          state_d = ST_REFILL;
        end
      end

      ST_WRITE_HIT: begin
        wen_sram         = 1'b1;
        dirty_d[line_q]  = 1'b1;
        state_d          = ST_IDLE;
      end

      ST_READ_HIT: begin
        demux_sel = 1'b1;
        state_d   = ST_IDLE;
      end

      ST_WRITEBACK: begin
        wr_rd_sdram = 1'b1;
        if (last_ack) begin
          dirty_d[line_q] = 1'b0;
          state_d         = flush_mode_q ? ST_FLUSH_SCAN : ST_REFILL;
        end
      end

      ST_REFILL: begin
        mux_sel  = 1'b1;
        wen_sram = mem_ack;
        if (last_ack) begin
          valid_d[line_q] = 1'b1;
          dirty_d[line_q] = 1'b0;
          tag_wen_d       = 1'b1;
          state_d         = wr_q ? ST_WRITE_HIT : ST_READ_HIT;
        end
      end

      ST_FLUSH_SCAN: begin
        // After a write-back the same line is revisited; it is clean by then.
        if (scan_dirty) begin
          line_d  = scan_q;
          state_d = ST_WRITEBACK;
        end else if (&scan_q) begin
          flush_done   = 1'b1;
          flush_mode_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          scan_d = scan_q + INDEX_W'(1);
          line_d = scan_q + INDEX_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Bench for cache_ctrl_fsm: table of CPU/flush operations with per-op pulse
// counts, plus a beat scoreboard checking every acked SDRAM word.
module tb_cache_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs;
  logic       wr_rd_cpu;
  logic [2:0] index;
  logic       tag_match;
  logic       flush;
  logic       mem_ack;
  logic       rdy;
  logic [2:0] line_idx;
  logic [4:0] addr_offset;
  logic       memstrb;
  logic       wr_rd_sdram;
  logic       mux_sel;
  logic       demux_sel;
  logic       wen_sram;
  logic       tag_wen;
  logic       flush_done;

  cache_ctrl_fsm #(.OFFSET_W(5), .INDEX_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .cs          (cs),
    .wr_rd_cpu   (wr_rd_cpu),
    .index       (index),
    .tag_match   (tag_match),
    .flush       (flush),
    .mem_ack     (mem_ack),
    .rdy         (rdy),
    .line_idx    (line_idx),
    .addr_offset (addr_offset),
    .memstrb     (memstrb),
    .wr_rd_sdram (wr_rd_sdram),
    .mux_sel     (mux_sel),
    .demux_sel   (demux_sel),
    .wen_sram    (wen_sram),
    .tag_wen     (tag_wen),
    .flush_done  (flush_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int is_flush; int cs; int wr; int idx; int tm; int delay;
    int wb_mask; int refill;
    int n_wen; int n_tag; int n_demux; int n_fd; int cycles;
  } vec_t;

  typedef struct { int wr; int line; int off; } beat_t;

  localparam int N_MAIN = 13;
  vec_t  vecs[N_MAIN+1];
  beat_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int ack_delay = 0;
  int stray_ack = 0;
  int wait_cnt  = 0;
  int wen_cnt, tag_cnt, demux_cnt, fd_cnt;
  int prev_hold = 0;
  int prev_off  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int is_flush, input int c, input int wr, input int idx,
                              input int tm, input int delay, input int wb_mask, input int refill,
                              input int n_wen, input int n_tag, input int n_demux, input int n_fd,
                              input int cycles);
    vec_t v;
    v.is_flush = is_flush; v.cs = c; v.wr = wr; v.idx = idx; v.tm = tm; v.delay = delay;
    v.wb_mask = wb_mask; v.refill = refill; v.n_wen = n_wen; v.n_tag = n_tag;
    v.n_demux = n_demux; v.n_fd = n_fd; v.cycles = cycles;
    return v;
  endfunction

  // SDRAM model: one ack per word after ack_delay idle cycles; stray acks outside bursts.
  always begin
    @(posedge clk);
    #1;
    if (memstrb) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      mem_ack  = (stray_ack != 0);
      wait_cnt = 0;
    end
  end

  // Monitor: pulse counters, scoreboard pop per accepted word, offset hold while stalled.
  always @(negedge clk) begin
    beat_t b;
    if (wen_sram)   wen_cnt++;
    if (tag_wen)    tag_cnt++;
    if (demux_sel)  demux_cnt++;
    if (flush_done) fd_cnt++;
    if (prev_hold != 0 && memstrb)
      check("offset_hold", int'(addr_offset), prev_off);
    if (memstrb && mem_ack) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got line %0d off %0d expected no beat", line_idx, addr_offset);
      end else begin
        b = sb.pop_front();
        check("beat_wr",   int'(wr_rd_sdram), b.wr);
        check("beat_line", int'(line_idx), b.line);
        check("beat_off",  int'(addr_offset), b.off);
        check("beat_mux",  int'(mux_sel), (b.wr == 0) ? 1 : 0);
      end
    end
    prev_hold = (memstrb && !mem_ack) ? 1 : 0;
    prev_off  = int'(addr_offset);
  end

  task automatic run_op(input int k);
    vec_t  v;
    beat_t b;
    int    cyc;
    v = vecs[k];
    ack_delay = v.delay;
    tag_match = (v.tm != 0);
    wen_cnt = 0; tag_cnt = 0; demux_cnt = 0; fd_cnt = 0;
    for (int l = 0; l < 8; l++) begin
      if (v.wb_mask[l]) begin
        for (int o = 0; o < 32; o++) begin
          b.wr = 1; b.line = l; b.off = o;
          sb.push_back(b);
        end
      end
    end
    if (v.refill != 0) begin
      for (int o = 0; o < 32; o++) begin
        b.wr = 0; b.line = v.idx; b.off = o;
        sb.push_back(b);
      end
    end
    cs        = (v.cs != 0);
    flush     = (v.is_flush != 0);
    wr_rd_cpu = (v.wr != 0);
    index     = 3'(v.idx);
    @(posedge clk);
    #1;
    cs    = 1'b0;
    flush = 1'b0;
    cyc   = 0;
    while (!rdy && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL op%0d_timeout: got rdy=0 after %0d cycles expected rdy=1", k, cyc);
    end
    check($sformatf("op%0d_wen", k),   wen_cnt,   v.n_wen);
    check($sformatf("op%0d_tagwen", k), tag_cnt,  v.n_tag);
    check($sformatf("op%0d_demux", k), demux_cnt, v.n_demux);
    check($sformatf("op%0d_fdone", k), fd_cnt,    v.n_fd);
    check($sformatf("op%0d_beats_left", k), sb.size(), 0);
    if (v.cycles != 0) check($sformatf("op%0d_cycles", k), cyc, v.cycles);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    //            fl cs wr idx tm dly wbmask  ref wen tag dmx fd cyc
    vecs[0]  = mk(0, 1, 0, 2, 0, 0, 'h00,   1, 32, 1, 1, 0, 34);  // cold read miss
    vecs[1]  = mk(0, 1, 1, 2, 1, 0, 'h00,   0,  1, 0, 0, 0,  2);  // write hit
    vecs[2]  = mk(0, 1, 0, 2, 0, 0, 'h04,   1, 32, 1, 1, 0, 66);  // dirty miss
    vecs[3]  = mk(0, 1, 0, 1, 0, 3, 'h00,   1, 32, 1, 1, 0, 130); // slow SDRAM
    vecs[4]  = mk(0, 1, 1, 1, 1, 0, 'h00,   0,  1, 0, 0, 0,  2);
    vecs[5]  = mk(0, 1, 0, 5, 0, 1, 'h00,   1, 32, 1, 1, 0, 66);
    vecs[6]  = mk(0, 1, 1, 5, 1, 0, 'h00,   0,  1, 0, 0, 0,  2);
    vecs[7]  = mk(0, 1, 0, 5, 1, 0, 'h00,   0,  0, 0, 1, 0,  2);  // read hit
    vecs[8]  = mk(1, 1, 0, 0, 0, 0, 'h22,   0,  0, 0, 0, 1, 74);  // flush beats cs
    vecs[9]  = mk(0, 1, 1, 3, 1, 0, 'h00,   1, 33, 1, 0, 0, 34);  // write miss, tag matches invalid line
    vecs[10] = mk(0, 1, 0, 1, 1, 0, 'h00,   0,  0, 0, 1, 0,  2);  // valid kept by flush
    vecs[11] = mk(0, 1, 0, 7, 1, 2, 'h00,   1, 32, 1, 1, 0, 98);
    vecs[12] = mk(1, 0, 0, 0, 0, 0, 'h08,   0,  0, 0, 0, 1, 41);
    vecs[13] = mk(0, 1, 0, 2, 1, 0, 'h00,   1, 32, 1, 1, 0, 34);  // after reset: line 2 invalid

    rst = 1'b1; cs = 1'b0; wr_rd_cpu = 1'b0; index = 3'd0;
    tag_match = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy",     int'(rdy), 1);
    check("rst_memstrb", int'(memstrb), 0);
    check("rst_offset",  int'(addr_offset), 0);
    check("rst_line",    int'(line_idx), 0);
    check("rst_outs",    int'({wr_rd_sdram, mux_sel, demux_sel, wen_sram, tag_wen, flush_done}), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int k = 0; k < N_MAIN; k++) run_op(k);

    // Stray acks while idle must not start or advance anything.
    stray_ack = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stray_memstrb", int'(memstrb), 0);
      check("stray_offset",  int'(addr_offset), 0);
      check("stray_rdy",     int'(rdy), 1);
    end
    stray_ack = 0;
    @(posedge clk);
    #1;

    // Reset in the middle of a refill burst.
    begin
      beat_t b;
      for (int o = 0; o < 32; o++) begin
        b.wr = 0; b.line = 4; b.off = o;
        sb.push_back(b);
      end
    end
    ack_delay = 0; tag_match = 1'b0;
    cs = 1'b1; wr_rd_cpu = 1'b0; index = 3'd4;
    @(posedge clk);
    #1;
    cs  = 1'b0;
    cyc = 0;
    while (!(memstrb && addr_offset == 5'd10) && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("abort_reached_10", int'(addr_offset), 10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_memstrb", int'(memstrb), 0);
    check("abort_offset",  int'(addr_offset), 0);
    check("abort_rdy",     int'(rdy), 1);
    check("abort_line",    int'(line_idx), 0);
    sb.delete();
    @(posedge clk);
    #1;
    check("abort_memstrb_hold", int'(memstrb), 0);

    run_op(N_MAIN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_ctrl_fsm.md
CACHE_CTRL_FSM -- requirements
Module: cache_ctrl_fsm

Interface
REQ-001 SHALL have parameter OFFSET_W, default 5, meaning block holds 2^OFFSET_W words.
REQ-002 SHALL have parameter INDEX_W, default 3, meaning cache holds 2^INDEX_W lines.
REQ-003 SHALL run on one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 cs  in  1  CPU request strobe, sampled only while rdy=1.
REQ-007 wr_rd_cpu  in  1  1=write, 0=read; sampled with cs.
REQ-008 index  in  INDEX_W  line index; sampled with cs.
REQ-009 tag_match  in  1  external tag compare for the latched line.
REQ-010 flush  in  1  write-back-all request, sampled only while rdy=1.
REQ-011 mem_ack  in  1  SDRAM accepted/returned the current word.
REQ-012 rdy  out  1  controller idle, accepting cs/flush.
REQ-013 line_idx  out  INDEX_W  line currently operated on.
REQ-014 addr_offset  out  OFFSET_W  word offset within block.
REQ-015 memstrb  out  1  SDRAM word request.
REQ-016 wr_rd_sdram  out  1  1=SDRAM write, 0=SDRAM read.
REQ-017 mux_sel  out  1  SRAM data source: 1=SDRAM, 0=CPU.
REQ-018 demux_sel  out  1  1=SRAM data to CPU.
REQ-019 wen_sram  out  1  SRAM word write enable.
REQ-020 tag_wen  out  1  one-cycle tag RAM update pulse.
REQ-021 flush_done  out  1  one-cycle flush completion pulse.

Function
REQ-022 SHALL hold per-line valid[] and dirty[] bit vectors internally; hit = tag_match & valid[line_idx].
REQ-023 States: IDLE, LOOKUP, WRITE_HIT, READ_HIT, WRITEBACK, REFILL, FLUSH_SCAN; all outputs Moore except wen_sram in REFILL.
REQ-024 IDLE: rdy=1; flush=1 -> FLUSH_SCAN (flush wins over simultaneous cs); else cs=1 -> latch wr_rd_cpu, index -> LOOKUP.
REQ-025 LOOKUP: hit&wr -> WRITE_HIT; hit&!wr -> READ_HIT; miss & valid & dirty -> WRITEBACK; other miss -> REFILL.
REQ-026 WRITE_HIT: wen_sram=1, mux_sel=0, set dirty[line_idx] -> IDLE.
REQ-027 READ_HIT: demux_sel=1 -> IDLE.
REQ-028 WRITEBACK: memstrb=1, wr_rd_sdram=1; memstrb held until mem_ack; each mem_ack advances addr_offset by 1.
REQ-029 WRITEBACK last-word ack (addr_offset=all-ones): clear dirty[line_idx], addr_offset->0; go REFILL (CPU miss) or FLUSH_SCAN (flush).
REQ-030 REFILL: memstrb=1, wr_rd_sdram=0, mux_sel=1, wen_sram=mem_ack; each ack advances addr_offset.
REQ-031 REFILL last-word ack: set valid[line_idx], clear dirty, tag_wen=1 next cycle, addr_offset->0, -> WRITE_HIT or READ_HIT per latched wr.
REQ-032 FLUSH_SCAN: scan pointer from 0; dirty&valid line -> WRITEBACK with line_idx=pointer; clean line -> pointer+1, one line per cycle.
REQ-033 FLUSH_SCAN after last line (pointer all-ones, clean): flush_done=1 one cycle, -> IDLE; valid[] unchanged.
REQ-034 mem_ack SHALL be ignored when memstrb=0; addr_offset wraps all-ones -> 0 only on last-word ack.
REQ-035 Miss latency with no write-back SHALL be 2 + 2^OFFSET_W ack cycles + 1 hit cycle minimum.

Reset
REQ-036 rst SHALL force IDLE, clear valid[], dirty[], addr_offset, scan pointer, line_idx, and drive rdy=1, all other outputs 0 on next edge.
REQ-037 rst mid-WRITEBACK/REFILL SHALL abort the burst; memstrb low the cycle after rst sampled.

Structure
REQ-038 State encodings and OFFSET_W/INDEX_W defaults SHALL live in shared package cache_pkg.
REQ-039 Burst word counter with ack-advance and last-word flag SHALL be sub-module cache_burst_cnt.

Verification
REQ-040 Reset, cs read idx 2, tag_match=0 -> REFILL 32 acks, wen_sram 32 pulses, tag_wen once, READ_HIT demux_sel=1, rdy back.
REQ-041 Write idx 2 after refill, tag_match=1 -> WRITE_HIT wen_sram=1 one cycle, dirty[2]=1, no memstrb.
REQ-042 Read idx 2 tag_match=0 with dirty[2] -> 32-word WRITEBACK (wr_rd_sdram=1) then 32-word REFILL, dirty[2]=0.
REQ-043 mem_ack delayed 3 cycles per word -> memstrb held high, addr_offset stable until ack; stray ack in IDLE ignored.
REQ-044 Lines 1,5 dirty, flush+cs same cycle -> flush wins, write-back line 1 then 5, flush_done one pulse, rdy=1.
REQ-045 rst at addr_offset=10 in REFILL -> IDLE, addr_offset=0, valid[] all 0, memstrb=0 next cycle.
